// File: rtl/rv32i_pkg.sv
// Shared types and encodings for the multi-cycle RV32I core: ALU op codes,
// opcodes, control FSM states and datapath mux selects.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0101
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_JAL, S_LUI, S_BRANCH, S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CLS_R, CLS_I, CLS_B
  } op_class_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for R-type, I-type and branch classes;
// valid is low for funct3 codes the core does not support.
module alu_decoder
  import rv32i_pkg::*;
(
  input  op_class_t  op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b0;
    if (op_class == CLS_B) begin
      // beq/bne compare by subtraction, blt/bge by the SLT result
      case (funct3)
        3'b000, 3'b001: begin alu_control = ALU_SUB; valid = 1'b1; end
        3'b100, 3'b101: begin alu_control = ALU_SLT; valid = 1'b1; end
        default: ;
      endcase
    end else begin
      case (funct3)
        3'b000: begin
          alu_control = (op_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          valid       = 1'b1;
        end
        3'b111: begin alu_control = ALU_AND; valid = 1'b1; end
        3'b110: begin alu_control = ALU_OR;  valid = 1'b1; end
        3'b010: begin alu_control = ALU_SLT; valid = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch through
// writeback and drives datapath selects, strobes and the ALU operation.
module multicycle_control
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  ctrl_state_t state, state_next;
  op_class_t   op_class;
  alu_op_t     dec_op;
  logic        dec_valid;
  logic        mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

  alu_decoder u_alu_decoder (
    .op_class    (op_class),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_op),
    .valid       (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    op_class    = CLS_R;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch/jump target computed into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        op_class    = CLS_R;
        alu_control = dec_op;
        state_next  = dec_valid ? S_ALUWB : S_TRAP;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        op_class    = CLS_I;
        alu_control = dec_op;
        state_next  = dec_valid ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        op_class    = CLS_B;
        alu_control = dec_op;
        // bne/blt take the branch on zero=0; beq/bge on zero=1
        pc_write_c  = dec_valid & (zero ^ (funct3[0] ^ funct3[2]));
        state_next  = dec_valid ? S_FETCH : S_TRAP;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign mem_req   = mem_req_c   & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each stimulus cycle queues its
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_control(alu_control),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,
  //  alu_src_a,alu_src_b,result_src,imm_src,alu_control,illegal}
  logic [19:0] dut_vec;
  assign dut_vec = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal};

  localparam logic [19:0] F_RST  = {6'b000000, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] F_RDY  = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] F_WAIT = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] D_B    = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000, 1'b0};
  localparam logic [19:0] D_J    = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 4'b0000, 1'b0};
  localparam logic [19:0] EXR_AD = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] EXR_SB = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 1'b0};
  localparam logic [19:0] WB_ALU = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] MA_LD  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] MA_ST  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000, 1'b0};
  localparam logic [19:0] MRD    = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] MWR    = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] WB_MEM = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] BR_TK  = {6'b000010, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 1'b0};
  localparam logic [19:0] BR_BLT = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0101, 1'b0};
  localparam logic [19:0] JAL_V  = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [19:0] TRAP_V = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1};

  localparam logic [6:0] OPR = 7'b0110011, OPL = 7'b0000011, OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011, OPJ = 7'b1101111, OPX = 7'b1111111;

  typedef struct {
    string       name;
    logic [19:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (dut_vec !== e.exp) begin
        failures++;
        $display("FAIL %s got=%05h expected=%05h", e.name, dut_vec, e.exp);
      end
    end
  end

  // Apply one cycle of inputs shortly after the rising edge and queue its expectation.
  task automatic step(input string name, input logic [6:0] op, input logic [2:0] f3,
                      input logic f75, input logic z, input logic rdy, input logic rst_v,
                      input logic [19:0] exp);
    exp_t e;
    opcode    = op;
    funct3    = f3;
    funct7_5  = f75;
    zero      = z;
    mem_ready = rdy;
    rst_n     = rst_v;
    e.name    = name;
    e.exp     = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step("rst_hold",      7'd0, 3'd0, 0, 0, 1, 0, F_RST);
    // add x3,x1,x2
    step("add_fetch",     OPR, 3'b000, 0, 0, 1, 1, F_RDY);
    step("add_decode",    OPR, 3'b000, 0, 0, 1, 1, D_B);
    step("add_exec",      OPR, 3'b000, 0, 0, 1, 1, EXR_AD);
    step("add_wb",        OPR, 3'b000, 0, 0, 1, 1, WB_ALU);
    // sub with one fetch wait cycle
    step("sub_fetch_w",   OPR, 3'b000, 1, 0, 0, 1, F_WAIT);
    step("sub_fetch",     OPR, 3'b000, 1, 0, 1, 1, F_RDY);
    step("sub_decode",    OPR, 3'b000, 1, 0, 0, 1, D_B);
    step("sub_exec",      OPR, 3'b000, 1, 0, 0, 1, EXR_SB);
    step("sub_wb",        OPR, 3'b000, 1, 0, 0, 1, WB_ALU);
    // lw with two MEMREAD wait cycles: 7 cycles
    step("lw_fetch",      OPL, 3'b010, 0, 0, 1, 1, F_RDY);
    step("lw_decode",     OPL, 3'b010, 0, 0, 1, 1, D_B);
    step("lw_memadr",     OPL, 3'b010, 0, 0, 1, 1, MA_LD);
    step("lw_memrd_w1",   OPL, 3'b010, 0, 0, 0, 1, MRD);
    step("lw_memrd_w2",   OPL, 3'b010, 0, 0, 0, 1, MRD);
    step("lw_memrd",      OPL, 3'b010, 0, 0, 1, 1, MRD);
    step("lw_memwb",      OPL, 3'b010, 0, 0, 1, 1, WB_MEM);
    // sw with one MEMWRITE wait cycle
    step("sw_fetch",      OPS, 3'b010, 0, 0, 1, 1, F_RDY);
    step("sw_decode",     OPS, 3'b010, 0, 0, 1, 1, D_B);
    step("sw_memadr",     OPS, 3'b010, 0, 0, 1, 1, MA_ST);
    step("sw_memwr_w",    OPS, 3'b010, 0, 0, 0, 1, MWR);
    step("sw_memwr",      OPS, 3'b010, 0, 0, 1, 1, MWR);
    // beq zero=1 taken
    step("beq_fetch",     OPB, 3'b000, 0, 1, 1, 1, F_RDY);
    step("beq_decode",    OPB, 3'b000, 0, 1, 1, 1, D_B);
    step("beq_branch",    OPB, 3'b000, 0, 1, 1, 1, BR_TK);
    // blt zero=1 not taken
    step("blt_fetch",     OPB, 3'b100, 0, 1, 1, 1, F_RDY);
    step("blt_decode",    OPB, 3'b100, 0, 1, 1, 1, D_B);
    step("blt_branch",    OPB, 3'b100, 0, 1, 1, 1, BR_BLT);
    // bne zero=0 taken
    step("bne_fetch",     OPB, 3'b001, 0, 0, 1, 1, F_RDY);
    step("bne_decode",    OPB, 3'b001, 0, 0, 1, 1, D_B);
    step("bne_branch",    OPB, 3'b001, 0, 0, 1, 1, BR_TK);
    // jal
    step("jal_fetch",     OPJ, 3'b000, 0, 0, 1, 1, F_RDY);
    step("jal_decode",    OPJ, 3'b000, 0, 0, 1, 1, D_J);
    step("jal_exec",      OPJ, 3'b000, 0, 0, 1, 1, JAL_V);
    step("jal_wb",        OPJ, 3'b000, 0, 0, 1, 1, WB_ALU);
    // reset asserted mid-FETCH while memory reports ready
    step("fetch_rst_mid", OPX, 3'b000, 0, 0, 1, 0, F_RST);
    step("fetch_post_rst",OPX, 3'b000, 0, 0, 1, 1, F_RDY);
    // illegal opcode 0x7F
    step("x7f_decode",    OPX, 3'b000, 0, 0, 1, 1, D_B);
    step("x7f_trap1",     OPX, 3'b000, 0, 0, 1, 1, TRAP_V);
    step("x7f_trap2",     OPR, 3'b000, 0, 1, 1, 1, TRAP_V);
    step("x7f_trap3",     OPB, 3'b000, 0, 1, 1, 1, TRAP_V);
    step("trap_rst",      OPR, 3'b011, 0, 0, 1, 0, F_RST);
    // add with unsupported funct3=011
    step("bad_fetch",     OPR, 3'b011, 0, 0, 1, 1, F_RDY);
    step("bad_decode",    OPR, 3'b011, 0, 0, 1, 1, D_B);
    step("bad_exec",      OPR, 3'b011, 0, 0, 1, 1, EXR_AD);
    step("bad_trap1",     OPR, 3'b011, 0, 0, 1, 1, TRAP_V);
    step("bad_trap2",     OPR, 3'b000, 0, 0, 1, 1, TRAP_V);

    begin
      int budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (sb_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
